// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 slave mapping framed transfers onto a
// 16 x 8-bit register bank with address auto-increment.
module spi_reg_responder #(
   parameter logic [7:0]  DEVICE_ID   = 8'hA5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         SPI_Clk,
   input  logic         SPI_CS,
   input  logic         SPI_MOSI,
   output logic         SPI_MISO,
   output logic         wr_strobe,
   output logic [3:0]   wr_addr,
   output logic [7:0]   wr_data,
   output logic [127:0] regs_flat,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic sclk_s, cs_s, mosi_s;
   logic sclk_prev_q, rise_q, fall_q;
   logic cs_seen_q;

   logic [2:0] cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d, rx_full;
   logic [7:0] tx_q, tx_d;
   logic [7:0] nxt_q, nxt_d;
   logic [3:0] addr_q, addr_d, addr_inc;
   logic       wr_strobe_q, wr_strobe_d;
   logic [3:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       we;
   logic [7:0] regs_q [16];

   assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign rx_full  = {rx_q[6:0], mosi_s};
   assign addr_inc = addr_q + 4'd1;

   // CS resets to "low" so a frame already in progress at reset release
   // is not mistaken for a new one; cs_seen_q arms the block once CS is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         cs_seen_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_Clk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
         sclk_prev_q <= sclk_s;
         rise_q      <= sclk_s & ~sclk_prev_q;
         fall_q      <= ~sclk_s & sclk_prev_q;
         if (cs_s) cs_seen_q <= 1'b1;
      end
   end

   // Frame state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, bit shifting, byte completion and write decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      nxt_d       = nxt_q;
      addr_d      = addr_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      we          = 1'b0;
      if (state_q == IDLE) begin
         if (!cs_s && cs_seen_q) begin
            state_d = CMD;
            tx_d    = DEVICE_ID;
            cnt_d   = '0;
         end
      end else if (cs_s) begin
         state_d = IDLE;
         tx_d    = '0;
         cnt_d   = '0;
      end else begin
         if (rise_q) begin
            rx_d  = rx_full;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               unique case (state_q)
                  CMD: begin
                     addr_d  = rx_full[3:0];
                     state_d = rx_full[7] ? RDATA : WDATA;
                     nxt_d   = rx_full[7] ? regs_q[rx_full[3:0]] : 8'h00;
                  end
                  WDATA: begin
                     we          = 1'b1;
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = addr_q;
                     wr_data_d   = rx_full;
                     addr_d      = addr_inc;
                     nxt_d       = 8'h00;
                  end
                  RDATA: begin
                     addr_d = addr_inc;
                     nxt_d  = regs_q[addr_inc];
                  end
                  default: ;
               endcase
            end
         end
         // cnt_q == 0 on a fall means a byte just completed: present the next
         if (fall_q) tx_d = (cnt_q == 3'd0) ? nxt_q : {tx_q[6:0], 1'b0};
      end
   end

   // Datapath and register bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         nxt_q       <= '0;
         addr_q      <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         nxt_q       <= nxt_d;
         addr_q      <= addr_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         if (we) regs_q[addr_q] <= rx_full;
      end
   end

   // Flatten the bank for core logic
   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < 16; i++) regs_flat[8*i +: 8] = regs_q[i];
   end

   assign SPI_MISO  = tx_q[7];
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = ~cs_s & cs_seen_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder: randomized SPI master with a register-bank model
// and queue-based scoreboard for write strobes and MISO bytes.
module tb_spi_reg_responder;

   localparam int HALF = 6;
   localparam logic [7:0] DEV = 8'hA5;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         SPI_Clk = 1'b0;
   logic         SPI_CS = 1'b1;
   logic         SPI_MOSI = 1'b0;
   logic         SPI_MISO;
   logic         wr_strobe;
   logic [3:0]   wr_addr;
   logic [7:0]   wr_data;
   logic [127:0] regs_flat;
   logic         busy;

   int checks = 0;
   int fails = 0;

   logic [7:0]  mem [16];
   logic [7:0]  data_buf [16];
   logic [7:0]  miso_exp_q [$];
   logic [7:0]  miso_got_q [$];
   logic [11:0] wr_exp_q [$];
   logic        strobe_prev = 1'b0;

   spi_reg_responder dut (
      .clk(clk),
      .reset(reset),
      .SPI_Clk(SPI_Clk),
      .SPI_CS(SPI_CS),
      .SPI_MOSI(SPI_MOSI),
      .SPI_MISO(SPI_MISO),
      .wr_strobe(wr_strobe),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .regs_flat(regs_flat),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Monitor: pops expected writes and MISO bytes as the DUT presents them
   always @(negedge clk) begin
      logic [11:0] e;
      logic [7:0]  g, x;
      if (wr_strobe) begin
         checks++;
         if (wr_exp_q.size() == 0) begin
            fails++;
            $display("FAIL wr_unexpected: got addr=%0d data=%02h, required no strobe",
                     wr_addr, wr_data);
         end else begin
            e = wr_exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               fails++;
               $display("FAIL wr_event: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        wr_addr, wr_data, e[11:8], e[7:0]);
            end
         end
         if (strobe_prev) begin
            checks++;
            fails++;
            $display("FAIL wr_width: strobe high 2 cycles, required 1");
         end
      end
      strobe_prev = wr_strobe;
      while (miso_got_q.size() > 0) begin
         g = miso_got_q.pop_front();
         checks++;
         if (miso_exp_q.size() == 0) begin
            fails++;
            $display("FAIL miso_extra: got %02h, required nothing", g);
         end else begin
            x = miso_exp_q.pop_front();
            if (g !== x) begin
               fails++;
               $display("FAIL miso_byte: got %02h, required %02h", g, x);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [127:0] got,
                      input logic [127:0] req);
      checks++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic check_regs();
      for (int i = 0; i < 16; i++)
         chk($sformatf("reg[%0d]", i), 128'(regs_flat[8*i +: 8]), 128'(mem[i]));
   endtask

   task automatic send_byte(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         SPI_MOSI = mo[7-i];
         cyc(HALF);
         mi[7-i] = SPI_MISO;
         SPI_Clk = 1'b1;
         cyc(HALF);
         SPI_Clk = 1'b0;
      end
   endtask

   task automatic cs_low();
      SPI_CS = 1'b0;
      cyc(HALF);
   endtask

   task automatic cs_high();
      cyc(HALF);
      SPI_CS = 1'b1;
      cyc(3 * HALF);
   endtask

   // Model a frame from the rules, queue expectations, then drive it
   task automatic do_frame(input logic [7:0] cmd, input int n, input int pbits);
      logic [7:0] mi;
      logic [3:0] ak;
      miso_exp_q.push_back(DEV);
      for (int k = 0; k < n; k++) begin
         ak = cmd[3:0] + 4'(k);
         if (cmd[7]) begin
            miso_exp_q.push_back(mem[ak]);
         end else begin
            wr_exp_q.push_back({ak, data_buf[k]});
            mem[ak] = data_buf[k];
         end
      end
      cs_low();
      send_byte(cmd, 8, mi);
      miso_got_q.push_back(mi);
      for (int k = 0; k < n; k++) begin
         send_byte(data_buf[k], 8, mi);
         if (cmd[7]) miso_got_q.push_back(mi);
      end
      if (pbits > 0) send_byte(data_buf[n], pbits, mi);
      cs_high();
   endtask

   initial begin
      logic [7:0] mi;
      int n, pb;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      cyc(3);
      chk("reset_regs", regs_flat, '0);
      chk("reset_miso", 128'(SPI_MISO), 0);
      chk("reset_busy", 128'(busy), 0);
      chk("reset_strobe", 128'(wr_strobe), 0);
      reset = 1'b0;
      cyc(3 * HALF);

      data_buf[0] = 8'hC1;
      do_frame(8'h03, 1, 0);
      check_regs();

      data_buf[0] = 8'hBE;
      data_buf[1] = 8'hEF;
      data_buf[2] = 8'h54;
      do_frame(8'h0E, 3, 0);
      check_regs();

      data_buf[0] = 8'h00;
      data_buf[1] = 8'h00;
      do_frame(8'h8E, 2, 0);

      data_buf[0] = 8'h77;
      do_frame(8'h05, 1, 0);
      data_buf[0] = 8'h3C;
      do_frame(8'h05, 0, 4);
      do_frame(8'h85, 1, 0);
      check_regs();

      miso_exp_q.push_back(DEV);
      cs_low();
      chk("busy_in_frame", 128'(busy), 1);
      send_byte(8'h02, 8, mi);
      miso_got_q.push_back(mi);
      send_byte(8'h5C, 4, mi);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      chk("rst_mid_regs", regs_flat, '0);
      chk("rst_mid_miso", 128'(SPI_MISO), 0);
      chk("rst_mid_busy", 128'(busy), 0);
      cyc(2);
      reset = 1'b0;
      send_byte(8'h5C, 4, mi);
      send_byte(8'h5C, 8, mi);
      chk("post_rst_busy", 128'(busy), 0);
      chk("post_rst_miso", 128'(SPI_MISO), 0);
      cs_high();
      check_regs();
      data_buf[0] = 8'h5C;
      do_frame(8'h02, 1, 0);
      check_regs();

      SPI_MOSI = 1'b1;
      for (int i = 0; i < 8; i++) begin
         SPI_Clk = 1'b1;
         cyc(HALF);
         chk("cs_high_busy", 128'(busy), 0);
         chk("cs_high_miso", 128'(SPI_MISO), 0);
         SPI_Clk = 1'b0;
         cyc(HALF);
      end
      check_regs();

      for (int f = 0; f < 30; f++) begin
         n = $urandom_range(0, 4);
         pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         for (int k = 0; k < 6; k++) data_buf[k] = 8'($urandom);
         do_frame(8'($urandom), n, pb);
      end
      check_regs();

      cyc(4);
      chk("wr_queue_empty", 128'(wr_exp_q.size()), 0);
      chk("miso_queue_empty", 128'(miso_exp_q.size()), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
